ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Two-port access controller for the 16x8 single-port data RAM. Arbitrates between two requesters,
//  e.g. CPU datapath (port 0) and switch/loader (port 1). Fair round-robin arbitration.
//  Drives the RAM address/data/write-enable inputs. Returns the registered RAM output to the
//  granted requester.
// PARAMETERS
//  ADDR_W  4  RAM address width (16 words)
//  DATA_W  8  RAM data width
// PORTS
//  clock           in   1       single system clock, all logic on posedge
//  reset_n         in   1       asynchronous, active-low reset
//  req0/req1       in   1       access request; hold with we/addr/wdata stable until gnt seen
//  we0/we1         in   1       1 = write, 0 = read
//  addr0/addr1     in   ADDR_W  word address
//  wdata0/wdata1   in   DATA_W  write data
//  gnt0/gnt1       out  1       one-cycle pulse: request accepted, requester may drop/change inputs
//  done0/done1     out  1       one-cycle pulse: access complete, rdataX valid
//  rdata0/rdata1   out  DATA_W  read data; held until next doneX of same port
//  ramAddress      out  ADDR_W  to RAM address
//  ramDataIn       out  DATA_W  to RAM dataIn
//  ramWriteEnable  out  1       to RAM writeEnable
//  ramDataOut      in   DATA_W  from RAM registered output (ledsSaida)
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; last_gnt=1; all outputs 0, incl. gnt*, done*, rdata*,
//    ram*. ramWriteEnable forced 0 immediately.
//  - FSM with 3 states, one access per 3 cycles:
//    IDLE:   any req sampled at edge -> pick winner. Register winner's addr/wdata/we into ram*.
//            Set gntX=1 and last_gnt=X. Go to ACCESS. No req: stay IDLE, ram* hold, we=0.
//    ACCESS: RAM samples ram* at closing edge. At that edge: ramWriteEnable<=0, gnt*<=0,
//            go to RESP. Store the winner id.
//    RESP:   ramDataOut valid. At closing edge: rdataX<=ramDataOut, doneX<=1 for one cycle.
//            Go to IDLE.
//  - Timing: req sampled at edge E -> gnt high in cycle E+1 -> done high in cycle E+3.
//    ramWriteEnable high exactly one cycle (ACCESS).
//  - Write completion: doneX pulses. rdataX = word contents BEFORE the write
//    (RAM read-before-write).
//  - Arbitration: a single requester always wins. Both requesting: grant port != last_gnt,
//    so port 0 wins the first tie after reset. Strict alternation while both held.
//  - Requests are ignored in ACCESS and RESP. A req still high in the following IDLE is a new request.
//  - Only one gnt and one done can be high in any cycle. gnt0&gnt1 and done0&done1 never both 1.
//  - Addresses are used modulo 2^ADDR_W. No range checking.
//  - Reset mid-operation: in ACCESS, the write is aborted (we cleared before the edge) and no done
//    is issued. In RESP, the done is dropped. RAM contents are not reset.
//  - Unused state encoding (2'd3) -> IDLE on next edge, outputs as reset.
// STRUCTURE
//  - ram_arb_pkg: ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2, default ADDR_W/DATA_W localparams.
//  - Sub-module rr_arbiter2: combinational two-way round-robin picker.
//    Inputs (req0, req1, last_gnt); outputs (valid, winner).
//  - Top: FSM, request mux, RAM-side registers, per-port rdata/done registers.
// TESTING
//  1. Write: req0, we0=1, addr0=4'h3, wdata0=8'h5A at edge E.
//     -> gnt0 in E+1; ramWriteEnable=1, ramAddress=3 only in E+1; done0 in E+3.
//  2. Read: req1, we1=0, addr1=4'h3 after test 1 -> done1 pulse. rdata1=8'h5A.
//     rdata0 unchanged.
//  3. Tie: req0 and req1 asserted together right after reset. Port 0 addr 4'h1, port 1 addr 4'h2.
//     -> gnt0 first, then gnt1 3 cycles later. Next tie -> port 0 first again (last was 1).
//  4. Both req held high for 12 cycles -> gnt sequence 0,1,0,1 spaced 3 cycles apart.
//     Never simultaneous gnt or done.
//  5. Reset_n=0 during ACCESS of write addr 4'h5, data 8'hFF -> ramWriteEnable drops at once.
//     No done. Readback of addr 5 returns the prior value.
//  6. Wrap: write 8'hC3 to addr 4'hF, then read 4'hF -> rdata=8'hC3. Force state 2'd3 -> IDLE next edge.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM access controller.
// Holds the FSM state encoding and the default RAM geometry.
// Imported by the interface and the top level.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  // Encoding 2'd3 is unused and recovers to idle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the single-port RAM.
// slave: arbiter view; master: requester and RAM view.
// Clock and reset stay outside as plain ports.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              done0, done1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] ramAddress;
  logic [DATA_W-1:0] ramDataIn;
  logic              ramWriteEnable;
  logic [DATA_W-1:0] ramDataOut;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ramDataOut,
    output gnt0, gnt1, done0, done1, rdata0, rdata1,
    output ramAddress, ramDataIn, ramWriteEnable
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ramDataOut,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1,
    input  ramAddress, ramDataIn, ramWriteEnable
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker, purely combinational.
// Latency: none (same cycle as the requests).
// Backpressure: none; the caller samples the result only when it can accept.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);

  // A lone requester always wins; a tie goes to the port not granted last.
  always_comb begin
    valid  = req0 | req1;
    winner = req1;
    if (req0 && req1) winner = ~last_gnt;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port access controller for a single-port RAM with registered output.
// Latency: gnt the cycle after the request edge, done two cycles after gnt.
// Backpressure: one access per 3 cycles; requests seen outside idle are ignored.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  ram_arbiter_if.slave  bus
);

  state_t            state;
  logic              last_gnt;
  logic              cur_port;
  logic              pick_vld;
  logic              pick_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter2 u_rr (
    .req0     (bus.req0),
    .req1     (bus.req1),
    .last_gnt (last_gnt),
    .valid    (pick_vld),
    .winner   (pick_port)
  );

  // Steer the winning port's command towards the RAM-side registers.
  always_comb begin
    sel_we    = pick_port ? bus.we1    : bus.we0;
    sel_addr  = pick_port ? bus.addr1  : bus.addr0;
    sel_wdata = pick_port ? bus.wdata1 : bus.wdata0;
  end

  // Access FSM; every output is registered and the pulses default low each cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_IDLE;
      last_gnt           <= 1'b1;
      cur_port           <= 1'b0;
      bus.gnt0           <= 1'b0;
      bus.gnt1           <= 1'b0;
      bus.done0          <= 1'b0;
      bus.done1          <= 1'b0;
      bus.rdata0         <= '0;
      bus.rdata1         <= '0;
      bus.ramAddress     <= '0;
      bus.ramDataIn      <= '0;
      bus.ramWriteEnable <= 1'b0;
    end else begin
      bus.gnt0           <= 1'b0;
      bus.gnt1           <= 1'b0;
      bus.done0          <= 1'b0;
      bus.done1          <= 1'b0;
      bus.ramWriteEnable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            bus.ramAddress     <= sel_addr;
            bus.ramDataIn      <= sel_wdata;
            bus.ramWriteEnable <= sel_we;
            bus.gnt0           <= ~pick_port;
            bus.gnt1           <= pick_port;
            last_gnt           <= pick_port;
            cur_port           <= pick_port;
            state              <= ST_ACCESS;
          end
        end
        // The RAM captures the command at the edge leaving this state.
        ST_ACCESS: state <= ST_RESP;
        // RAM output now reflects the word as it was before any write.
        ST_RESP: begin
          if (cur_port) begin
            bus.rdata1 <= bus.ramDataOut;
            bus.done1  <= 1'b1;
          end else begin
            bus.rdata0 <= bus.ramDataOut;
            bus.done0  <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: begin
          state          <= ST_IDLE;
          last_gnt       <= 1'b1;
          cur_port       <= 1'b0;
          bus.rdata0     <= '0;
          bus.rdata1     <= '0;
          bus.ramAddress <= '0;
          bus.ramDataIn  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic.
// A transaction-level model (memory array, free-at edge, pending access) predicts every cycle.
// Requesters hold their command until they see their grant.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Single-port RAM, read-before-write, registered output, never reset.
  logic [DW-1:0] ram [16];
  always @(posedge clock) begin
    if (bus.ramWriteEnable) ram[bus.ramAddress] <= bus.ramDataIn;
    bus.ramDataOut <= ram[bus.ramAddress];
  end

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int            edge_no   = 0;
  int            next_free = 0;
  logic          m_last;
  logic [7:0]    mm [16];
  logic [15:0]   mm_known  = '0;
  logic [7:0]    m_rd0, m_rd1, m_din;
  logic [3:0]    m_addr;
  logic          rk0, rk1;
  logic          pv = 1'b0;
  logic          p_port, p_we, p_known;
  logic [3:0]    p_addr;
  logic [7:0]    p_wdata, p_data;
  int            p_acc;
  logic          e_g0, e_g1, e_d0, e_d1, e_we;
  logic          hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pv = 1'b0; next_free = 0; m_last = 1'b1;
    m_rd0 = '0; m_rd1 = '0; rk0 = 1'b1; rk1 = 1'b1;
    m_addr = '0; m_din = '0;
    e_g0 = 1'b0; e_g1 = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0; e_we = 1'b0;
  endtask

  task automatic check_outputs();
    chk("gnt0",     32'(bus.gnt0),           32'(e_g0));
    chk("gnt1",     32'(bus.gnt1),           32'(e_g1));
    chk("done0",    32'(bus.done0),          32'(e_d0));
    chk("done1",    32'(bus.done1),          32'(e_d1));
    chk("ram_we",   32'(bus.ramWriteEnable), 32'(e_we));
    chk("ram_addr", 32'(bus.ramAddress),     32'(m_addr));
    chk("ram_din",  32'(bus.ramDataIn),      32'(m_din));
    chk("gnt_excl", 32'(bus.gnt0 & bus.gnt1),   0);
    chk("done_excl",32'(bus.done0 & bus.done1), 0);
    if (rk0) chk("rdata0", 32'(bus.rdata0), 32'(m_rd0));
    if (rk1) chk("rdata1", 32'(bus.rdata1), 32'(m_rd1));
  endtask

  // One clock: capture driven inputs, advance the model at the edge, check at negedge.
  task automatic step();
    logic q0, q1, w0, w1, win;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    q0 = bus.req0; q1 = bus.req1; w0 = bus.we0; w1 = bus.we1;
    a0 = bus.addr0; a1 = bus.addr1; d0 = bus.wdata0; d1 = bus.wdata1;
    @(posedge clock);
    edge_no++;
    e_g0 = 1'b0; e_g1 = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0; e_we = 1'b0;
    if (pv && edge_no == p_acc) begin
      p_data  = mm[p_addr];
      p_known = mm_known[p_addr];
      if (p_we) begin
        mm[p_addr] = p_wdata;
        mm_known[p_addr] = 1'b1;
      end
    end
    if (pv && edge_no == p_acc + 1) begin
      if (p_port) begin e_d1 = 1'b1; m_rd1 = p_data; rk1 = p_known; end
      else        begin e_d0 = 1'b1; m_rd0 = p_data; rk0 = p_known; end
      pv = 1'b0;
    end
    if (edge_no >= next_free && (q0 || q1)) begin
      win = (q0 && q1) ? ~m_last : q1;
      m_last = win;
      if (win) begin e_g1 = 1'b1; e_we = w1; m_addr = a1; m_din = d1; end
      else     begin e_g0 = 1'b1; e_we = w0; m_addr = a0; m_din = d0; end
      pv = 1'b1; p_port = win; p_we = e_we; p_addr = m_addr; p_wdata = m_din;
      p_acc = edge_no + 1; next_free = edge_no + 3;
    end
    @(negedge clock);
    check_outputs();
    if (!hold) begin
      if (bus.gnt0) bus.req0 = 1'b0;
      if (bus.gnt1) bus.req1 = 1'b0;
    end
  endtask

  // Called at a negedge: assert reset, check the reset state, release two cycles later.
  task automatic do_reset();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_gnt0",  32'(bus.gnt0), 0);
    chk("rst_gnt1",  32'(bus.gnt1), 0);
    chk("rst_done0", 32'(bus.done0), 0);
    chk("rst_done1", 32'(bus.done1), 0);
    chk("rst_rdata0",32'(bus.rdata0), 0);
    chk("rst_rdata1",32'(bus.rdata1), 0);
    chk("rst_addr",  32'(bus.ramAddress), 0);
    chk("rst_din",   32'(bus.ramDataIn), 0);
    chk("rst_we",    32'(bus.ramWriteEnable), 0);
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + 5);
  endfunction

  // Full transaction on one port; returns at the negedge where done is visible.
  task automatic xact(input logic port, input logic we, input logic [3:0] addr, input logic [7:0] wdata);
    logic got;
    got = 1'b0;
    if (port) begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; end
    else      begin bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; end
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = port ? bus.gnt1 : bus.gnt0;
    end
    if (!got) begin
      chk("xact_gnt_timeout", 0, 1);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
    end
    repeat (2) step();
  endtask

  initial begin
    logic [11:0] g0s, g1s;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    model_reset();
    @(negedge clock);
    do_reset();

    // Tie right after reset: port 0 first, port 1 three cycles later, next tie port 0 again.
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'h1;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'h2;
    step();
    chk("t3_first_gnt0", 32'(bus.gnt0), 1);
    repeat (2) step();
    step();
    chk("t3_then_gnt1", 32'(bus.gnt1), 1);
    repeat (2) step();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step();
    chk("t3_next_tie_gnt0", 32'(bus.gnt0), 1);
    repeat (5) step();

    // Fill every word with known contents.
    for (int i = 0; i < 16; i++) xact(1'b1, 1'b1, 4'(i), init_val(i));

    // Write 5A to address 3 on port 0 with exact cycle placement.
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'h3; bus.wdata0 = 8'h5A;
    step();
    chk("t1_gnt0", 32'(bus.gnt0), 1);
    chk("t1_we",   32'(bus.ramWriteEnable), 1);
    chk("t1_addr", 32'(bus.ramAddress), 3);
    step();
    chk("t1_we_one_cycle", 32'(bus.ramWriteEnable), 0);
    step();
    chk("t1_done0", 32'(bus.done0), 1);
    chk("t1_old_word", 32'(bus.rdata0), 32'(init_val(3)));

    // Read address 3 back on port 1.
    xact(1'b1, 1'b0, 4'h3, 8'h00);
    chk("t2_done1", 32'(bus.done1), 1);
    chk("t2_rdata1", 32'(bus.rdata1), 32'h5A);
    chk("t2_rdata0_held", 32'(bus.rdata0), 32'(init_val(3)));

    // Both held for 12 cycles: strict alternation every 3 cycles.
    do_reset();
    hold = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'h7;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'h8;
    for (int i = 0; i < 12; i++) begin
      step();
      g0s[i] = bus.gnt0;
      g1s[i] = bus.gnt1;
    end
    hold = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("t4_gnt0_seq", 32'(g0s), 32'h041);
    chk("t4_gnt1_seq", 32'(g1s), 32'h208);
    repeat (3) step();

    // Reset during the access cycle of a write aborts it.
    xact(1'b0, 1'b1, 4'h5, 8'h11);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'h5; bus.wdata0 = 8'hFF;
    step();
    chk("t5_gnt0", 32'(bus.gnt0), 1);
    chk("t5_we_before", 32'(bus.ramWriteEnable), 1);
    do_reset();
    xact(1'b1, 1'b0, 4'h5, 8'h00);
    chk("t5_readback", 32'(bus.rdata1), 32'h11);

    // Top address and recovery from the unused state encoding.
    xact(1'b0, 1'b1, 4'hF, 8'hC3);
    xact(1'b0, 1'b0, 4'hF, 8'h00);
    chk("t6_rdata0", 32'(bus.rdata0), 32'hC3);
    force dut.state = state_t'(2'd3);
    @(posedge clock);
    #1 release dut.state;
    edge_no++;
    model_reset();
    @(negedge clock);
    check_outputs();
    step();
    xact(1'b1, 1'b0, 4'hF, 8'h00);
    chk("t6_after_bad_state", 32'(bus.rdata1), 32'hC3);

    // Random traffic from both ports.
    for (int c = 0; c < 500; c++) begin
      if (!bus.req0 && $urandom_range(2) == 0) begin
        bus.req0 = 1'b1; bus.we0 = 1'($urandom_range(1));
        bus.addr0 = 4'($urandom_range(15)); bus.wdata0 = 8'($urandom_range(255));
      end
      if (!bus.req1 && $urandom_range(2) == 0) begin
        bus.req1 = 1'b1; bus.we1 = 1'($urandom_range(1));
        bus.addr1 = 4'($urandom_range(15)); bus.wdata1 = 8'($urandom_range(255));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
